// File: rtl/apb_pkg.sv
// Shared APB definitions: bus width defaults, transfer direction and the
// completer FSM state encoding.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } wr_rd_en;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        WAIT   = 2'd2,
        ACCESS = 2'd3
    } apb_slv_state_e;

endpackage

// File: rtl/apb_slv_mem_array.sv
// Word memory built from one byte-wide array per lane: synchronous
// byte-enabled write, asynchronous read, and full clear on reset.
module apb_slv_mem_array #(
    parameter  int DEPTH      = 256,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [STRB_WIDTH-1:0] i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (srst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_mem[k] <= '0;
                    end
                end else if (i_we[gi]) begin
                    r_mem[i_waddr] <= i_wdata[gi*8 +: 8];
                end
            end

            assign o_rdata[gi*8 +: 8] = r_mem[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a byte-strobed word memory with range error.
// Define APB_SLV_WAIT_EN to build the optional slave-inserted wait states.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  wr_rd_en               PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_WIDTH-1:0] PSTRB,
    input  logic [2:0]            PPROT,
    input  logic                  PWAKEUP,
    input  logic                  delay_by_slave_module,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int LSB    = $clog2(STRB_WIDTH);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int MEM_AW = $clog2(MEM_DEPTH);

    apb_slv_state_e        r_state, w_state, w_next;
    logic [MEM_AW-1:0]     r_index;
    wr_rd_en               r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_strb;
    logic                  r_err;
    logic                  r_pready;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_pslverr;

    logic                  w_setup, w_xfer, w_err;
    logic                  w_cur_err;
    wr_rd_en               w_cur_write;
    logic [MEM_AW-1:0]     w_rd_addr;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic [STRB_WIDTH-1:0] w_mem_we;
    logic                  w_pready_next, w_pslverr_next;
    logic [DATA_WIDTH-1:0] w_prdata_next;
    logic                  w_unused;

    assign w_setup = PSELx & ~PENABLE;
    assign w_xfer  = PSELx & PENABLE;
    assign w_err   = {1'b0, PADDR[ADDR_WIDTH-1:LSB]} >= (IDX_W + 1)'(MEM_DEPTH);

    // The setup cycle is recognised from IDLE so PREADY can be registered
    // for the very next cycle.
    assign w_state = (r_state == IDLE && w_setup) ? SETUP : r_state;

`ifdef APB_SLV_WAIT_EN
    logic [3:0] r_cnt;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_cnt <= '0;
        end else if (w_state == SETUP) begin
            r_cnt <= 4'(WAIT_CYCLES - 1);
        end else if (w_state == WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end
    assign w_unused = ^{PPROT, PWAKEUP, PADDR};
`else
    assign w_unused = ^{PPROT, PWAKEUP, PADDR, delay_by_slave_module};
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= IDLE;
            r_index   <= '0;
            r_write   <= READ;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_state == SETUP) begin
                r_index <= PADDR[LSB +: MEM_AW];
                r_write <= PWRITE;
                r_wdata <= PWDATA;
                r_strb  <= PSTRB;
                r_err   <= w_err;
            end
            r_pready  <= w_pready_next;
            r_prdata  <= w_prdata_next;
            r_pslverr <= w_pslverr_next;
        end
    end

    always_comb begin
        w_next = IDLE;
        case (w_state)
            SETUP: begin
                w_next = ACCESS;
`ifdef APB_SLV_WAIT_EN
                if (delay_by_slave_module && (WAIT_CYCLES > 0)) begin
                    w_next = WAIT;
                end
`endif
            end
`ifdef APB_SLV_WAIT_EN
            WAIT: begin
                if (!w_xfer) begin
                    w_next = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next = ACCESS;
                end else begin
                    w_next = WAIT;
                end
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_cur_err      = (w_state == SETUP) ? w_err  : r_err;
        w_cur_write    = (w_state == SETUP) ? PWRITE : r_write;
        w_rd_addr      = (w_state == SETUP) ? PADDR[LSB +: MEM_AW] : r_index;
        w_pready_next  = (w_next == ACCESS);
        w_pslverr_next = w_pready_next && w_cur_err;
        w_prdata_next  = '0;
        if (w_pready_next && !w_cur_err && w_cur_write == READ) begin
            w_prdata_next = w_mem_rdata;
        end
        w_mem_we = '0;
        if (r_state == ACCESS && w_xfer && r_write == WRITE && !r_err) begin
            w_mem_we = r_strb;
        end
    end

    apb_slv_mem_array #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (PCLK),
        .srst    (PRESET),
        .i_we    (w_mem_we),
        .i_waddr (r_index),
        .i_wdata (r_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_mem_rdata)
    );

    assign PREADY  = r_pready;
    assign PRDATA  = r_prdata;
    assign PSLVERR = r_pslverr;

endmodule
